// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_controller
//  Description : Walks the select lines of a 4:1 gate-level mux through
//                addresses 0..3. After each select change it waits
//                SETTLE_CYCLES clocks, then captures the mux output into a
//                4-bit sample word. The word is delivered over a valid/ready
//                handshake.
//  Options     : `define MUX_SCAN_PARITY_EN adds a registered parity output
//                (XOR of the sample word).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 4,    // legal range 1..7
    parameter int CNT_W         = 3     // 2**CNT_W must exceed SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       mux_out,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic [3:0] sample,
    output logic       valid,
    input  logic       ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sample;
    logic             r_valid;
    logic             r_busy;
`ifdef MUX_SCAN_PARITY_EN
    logic             r_parity;
`endif

    // Scan sequencer: all outputs are registered so the select lines only
    // ever change on a clock edge and never glitch into the mux.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= 2'd0;
            r_cnt    <= '0;
            r_sample <= 4'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_addr  <= 2'd0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Hold the address until the mux output has had time
                    // to propagate through its gate chain.
                    if (r_cnt == c_settle_last) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_CAPTURE: begin
                    r_sample[r_addr] <= mux_out;
                    if (r_addr == 2'd3) begin
                        r_state <= ST_HOLD;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                        // Last bit lands on this edge, so fold it in
                        // directly rather than reading the old sample.
                        r_parity <= ^{mux_out, r_sample[2:0]};
`endif
                    end else begin
                        r_state <= ST_SETTLE;
                        r_addr  <= r_addr + 2'd1;
                        r_cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    // Word stays put until the consumer takes it; a start
                    // seen together with ready chains straight into a scan.
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_addr  <= 2'd0;
                        r_cnt   <= '0;
                        if (start) begin
                            r_state <= ST_SETTLE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign address0 = r_addr[0];
    assign address1 = r_addr[1];
    assign busy     = r_busy;
    assign valid    = r_valid;
    assign sample   = r_sample;
`ifdef MUX_SCAN_PARITY_EN
    assign parity   = r_parity;
`endif

endmodule
`default_nettype wire
